// File: rtl/ps2_rx_fifo_if.sv
// Read-side handshake of the PS/2 receive FIFO: head scan code plus valid/ready.
// master = FIFO (drives the head), slave = consumer (drives rd_ready).
interface ps2_rx_fifo_if;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       rd_ext;
  logic       rd_brk;

  modport master (output rd_valid, output rd_data, output rd_ext, output rd_brk, input rd_ready);
  modport slave  (input rd_valid, input rd_data, input rd_ext, input rd_brk, output rd_ready);
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronise, deframe, check, buffer scan codes in a FIFO.
// Define PS2_BREAK_DECODE_EN to fold E0/F0 prefixes into ext/brk flags on the entries.
//
// state  | meaning
// S_IDLE | waiting for a ps2_clk fall with data low (start bit)
// S_RECV | shifting bits 1..10 in; timeout timer running between falls
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 50000,
  parameter int CNT_W       = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  ps2_rx_fifo_if.master                 rd,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          parity_err,
  output logic                          frame_err,
  input  logic                          clr_err,
  output logic [CNT_W-1:0]              byte_cnt
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
`ifdef PS2_BREAK_DECODE_EN
  localparam int ENTRY_W = 10;
`else
  localparam int ENTRY_W = 8;
`endif

  typedef enum logic {S_IDLE, S_RECV} state_t;

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev;
  logic                   fall, bit_in;

  state_t             state_q, state_d;
  logic [3:0]         bit_idx;
  logic [7:0]         shreg;
  logic               par_q;
  logic [TMR_W-1:0]   tmr_q;
  logic               frame_done, tmo;
  logic               byte_ok, par_set, frm_set, err_any;

  logic               push_req, do_push, pop, full, empty, ovf_set;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;

  // Reset to 1 so the idle-high lines never look like a fall coming out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign bit_in = data_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    tmo        = 1'b0;
    case (state_q)
      S_IDLE: if (fall && !bit_in) state_d = S_RECV;
      S_RECV: begin
        if (fall && bit_idx == 4'd10) begin
          state_d    = S_IDLE;
          frame_done = 1'b1;
        end else if (!fall && tmr_q == '0) begin
          state_d = S_IDLE;
          tmo     = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Timer is a down-counter reloaded on every fall; terminal count means the frame stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_idx <= '0;
      shreg   <= '0;
      par_q   <= 1'b0;
      tmr_q   <= '0;
    end else if (state_q == S_IDLE) begin
      if (fall && !bit_in) begin
        bit_idx <= 4'd1;
        tmr_q   <= TMR_W'(TIMEOUT_CYC - 1);
      end
    end else if (fall) begin
      bit_idx <= bit_idx + 4'd1;
      tmr_q   <= TMR_W'(TIMEOUT_CYC - 1);
      if (bit_idx <= 4'd8) shreg <= {bit_in, shreg[7:1]};
      if (bit_idx == 4'd9) par_q <= bit_in;
    end else if (tmr_q != '0) begin
      tmr_q <= tmr_q - 1'b1;
    end
  end

  assign par_set = frame_done & ~(^{shreg, par_q});
  assign frm_set = (frame_done & ~bit_in) | tmo;
  assign err_any = par_set | frm_set;
  assign byte_ok = frame_done & (^{shreg, par_q}) & bit_in;

`ifdef PS2_BREAK_DECODE_EN
  logic pend_ext, pend_brk, is_e0, is_f0;

  assign is_e0      = (shreg == 8'hE0);
  assign is_f0      = (shreg == 8'hF0);
  assign push_req   = byte_ok & ~is_e0 & ~is_f0;
  assign push_entry = {pend_ext, pend_brk, shreg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_ext <= 1'b0;
      pend_brk <= 1'b0;
    end else if (err_any) begin
      pend_ext <= 1'b0;
      pend_brk <= 1'b0;
    end else if (byte_ok) begin
      if (is_e0)      pend_ext <= 1'b1;
      else if (is_f0) pend_brk <= 1'b1;
      else begin
        pend_ext <= 1'b0;
        pend_brk <= 1'b0;
      end
    end
  end

  assign rd.rd_ext = ~empty & mem[rd_ptr][9];
  assign rd.rd_brk = ~empty & mem[rd_ptr][8];
`else
  assign push_req   = byte_ok;
  assign push_entry = shreg;
  assign rd.rd_ext  = 1'b0;
  assign rd.rd_brk  = 1'b0;
`endif

  assign empty   = (fifo_count == '0);
  assign full    = (fifo_count == (AW+1)'(FIFO_DEPTH));
  assign pop     = rd.rd_ready & ~empty;
  assign do_push = push_req & (~full | pop);
  assign ovf_set = push_req & full & ~pop;

  assign rd.rd_valid = ~empty;
  assign rd.rd_data  = empty ? 8'h00 : mem[rd_ptr][7:0];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      byte_cnt   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        byte_cnt <= byte_cnt + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (!do_push && pop) fifo_count <= fifo_count - 1'b1;
    end
  end

  // A set event in the same cycle as clr_err wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (par_set)      parity_err <= 1'b1;
      else if (clr_err) parity_err <= 1'b0;
      if (frm_set)      frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end

endmodule
